// File: rtl/spi_serializer_if.sv
// Word-write side and serial-output side of the per-channel transmit serializer.
// The master modport belongs to the word writer; the serializer uses the slave modport.
interface spi_serializer_if;
  logic [15:0] data;
  logic        ena;
  logic        last;
  logic        odd;
  logic        busy;
  logic        ovf;
  logic        tx_data;
  logic        tx_load;
  logic        tx_stop;
  logic        msg_done;

  modport master (
    output data, ena, last, odd,
    input  busy, ovf, tx_data, tx_load, tx_stop, msg_done
  );

  modport slave (
    input  data, ena, last, odd,
    output busy, ovf, tx_data, tx_load, tx_stop, msg_done
  );
endinterface

// File: rtl/spi_serializer.sv
// Buffers 16-bit words in a small FIFO and sends them as MSB-first bytes framed by
// tx_load, closing each message with a tx_stop pulse.
module spi_serializer #(
  parameter int FIFO_DEPTH = 16,
  parameter int GAP_CYCLES = 2,
  parameter int STOP_LEN   = 1
) (
  input logic            clk,
  input logic            rst_n,
  spi_serializer_if.slave bus
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int GAP_W  = $clog2(GAP_CYCLES + 1);
  localparam int STOP_W = $clog2(STOP_LEN + 1);
  localparam logic [CNT_W-1:0]  DEPTH_C   = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0]  BUSY_TH   = CNT_W'(FIFO_DEPTH - 2);
  localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(GAP_CYCLES - 1);
  localparam logic [STOP_W-1:0] STOP_LAST = STOP_W'(STOP_LEN - 1);

  typedef enum logic [2:0] {ST_IDLE, ST_SHIFT, ST_GAP, ST_WAIT, ST_STOP} state_t;

  logic [17:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_reg, rd_ptr_reg;
  logic [CNT_W-1:0]  count_reg, count_next;
  logic              busy_reg, ovf_reg;
  logic              push, pop;
  logic [17:0]       head;

  state_t            state_reg;
  logic [15:0]       sreg_reg;
  logic [2:0]        bit_cnt_reg;
  logic [GAP_W-1:0]  gap_cnt_reg;
  logic [STOP_W-1:0] stop_cnt_reg;
  logic              hi_byte_reg, cur_last_reg, cur_odd_reg;
  logic              tx_data_reg, tx_load_reg, tx_stop_reg, msg_done_reg;
  logic              gap_done, final_byte;

  assign head       = mem[rd_ptr_reg];
  assign gap_done   = (gap_cnt_reg == GAP_LAST);
  // An ODD-flagged last word ends after its high byte; ODD alone means nothing.
  assign final_byte = cur_last_reg && (!hi_byte_reg || cur_odd_reg);

  always_comb begin
    pop = 1'b0;
    if (count_reg != '0) begin
      case (state_reg)
        ST_IDLE, ST_WAIT: pop = 1'b1;
        ST_GAP:           pop = gap_done && !hi_byte_reg && !cur_last_reg;
        default:          pop = 1'b0;
      endcase
    end
  end

  assign push = bus.ena && ((count_reg != DEPTH_C) || pop);

  always_comb begin
    count_next = count_reg;
    if (push && !pop)
      count_next = count_reg + CNT_W'(1);
    else if (pop && !push)
      count_next = count_reg - CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr_reg] <= {bus.last, bus.odd, bus.data};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      busy_reg   <= 1'b0;
      ovf_reg    <= 1'b0;
    end else begin
      if (push)
        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (pop)
        rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      count_reg <= count_next;
      busy_reg  <= (count_next >= BUSY_TH);
      if (bus.ena && !push)
        ovf_reg <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= ST_IDLE;
      sreg_reg     <= '0;
      bit_cnt_reg  <= '0;
      gap_cnt_reg  <= '0;
      stop_cnt_reg <= '0;
      hi_byte_reg  <= 1'b0;
      cur_last_reg <= 1'b0;
      cur_odd_reg  <= 1'b0;
      tx_data_reg  <= 1'b0;
      tx_load_reg  <= 1'b0;
      tx_stop_reg  <= 1'b0;
      msg_done_reg <= 1'b0;
    end else begin
      case (state_reg)
        ST_SHIFT: begin
          sreg_reg <= {sreg_reg[14:0], 1'b0};
          if (bit_cnt_reg == 3'd7) begin
            state_reg   <= ST_GAP;
            gap_cnt_reg <= '0;
            tx_load_reg <= 1'b0;
            tx_data_reg <= 1'b0;
          end else begin
            bit_cnt_reg <= bit_cnt_reg + 3'd1;
            tx_data_reg <= sreg_reg[14];
          end
        end
        ST_GAP: begin
          if (!gap_done) begin
            gap_cnt_reg <= gap_cnt_reg + GAP_W'(1);
          end else if (final_byte) begin
            state_reg    <= ST_STOP;
            stop_cnt_reg <= '0;
            tx_stop_reg  <= 1'b1;
            msg_done_reg <= (STOP_LEN == 1);
          end else if (hi_byte_reg) begin
            // Low byte already sits at the top of the shift register.
            state_reg   <= ST_SHIFT;
            hi_byte_reg <= 1'b0;
            bit_cnt_reg <= '0;
            tx_load_reg <= 1'b1;
            tx_data_reg <= sreg_reg[15];
          end else if (!pop) begin
            state_reg <= ST_WAIT;
          end
        end
        ST_STOP: begin
          if (stop_cnt_reg == STOP_LAST) begin
            state_reg    <= ST_IDLE;
            tx_stop_reg  <= 1'b0;
            msg_done_reg <= 1'b0;
          end else begin
            stop_cnt_reg <= stop_cnt_reg + STOP_W'(1);
            msg_done_reg <= ((stop_cnt_reg + STOP_W'(1)) == STOP_LAST);
          end
        end
        default: ;
      endcase

      // Every pop loads a fresh word and starts its high byte on the same edge.
      if (pop) begin
        state_reg    <= ST_SHIFT;
        sreg_reg     <= head[15:0];
        cur_last_reg <= head[17];
        cur_odd_reg  <= head[16];
        hi_byte_reg  <= 1'b1;
        bit_cnt_reg  <= '0;
        tx_load_reg  <= 1'b1;
        tx_data_reg  <= head[15];
      end
    end
  end

  assign bus.busy     = busy_reg;
  assign bus.ovf      = ovf_reg;
  assign bus.tx_data  = tx_data_reg;
  assign bus.tx_load  = tx_load_reg;
  assign bus.tx_stop  = tx_stop_reg;
  assign bus.msg_done = msg_done_reg;

endmodule

// File: tb/tb_spi_serializer.sv
// Bench for spi_serializer: directed scenarios plus random words, every cycle compared
// against a reference that expands each popped word into its expected output waveform.
module tb_spi_serializer;

  localparam int FIFO_DEPTH = 16;
  localparam int GAP_CYCLES = 2;
  localparam int STOP_LEN   = 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  spi_serializer_if bus ();

  spi_serializer #(
    .FIFO_DEPTH(FIFO_DEPTH),
    .GAP_CYCLES(GAP_CYCLES),
    .STOP_LEN  (STOP_LEN)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Reference: queued words, and per-cycle expected {load,data,stop,done} samples.
  logic [17:0] mfifo[$];
  logic [3:0]  wave[$];
  logic        m_ovf = 1'b0;
  int          n_checks = 0;
  int          n_fail = 0;
  int          cyc = 0;

  function automatic void push_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) wave.push_back({1'b1, b[i], 2'b00});
    for (int i = 0; i < GAP_CYCLES; i++) wave.push_back(4'b0000);
  endfunction

  function automatic void push_stop();
    for (int i = 0; i < STOP_LEN; i++) wave.push_back({3'b001, (i == STOP_LEN - 1)});
    wave.push_back(4'b0000);  // idle cycle before the next pop
  endfunction

  function automatic void expand(input logic [17:0] w);
    push_byte(w[15:8]);
    if (w[17] && w[16]) begin
      push_stop();
    end else begin
      push_byte(w[7:0]);
      if (w[17]) push_stop();
    end
  endfunction

  task automatic model_edge();
    logic pop, acc;
    if (!rst_n) begin
      mfifo.delete();
      wave.delete();
      m_ovf = 1'b0;
      return;
    end
    if (wave.size() > 0) void'(wave.pop_front());
    pop = (wave.size() == 0) && (mfifo.size() > 0);
    acc = bus.ena && ((mfifo.size() < FIFO_DEPTH) || pop);
    if (bus.ena && !acc) m_ovf = 1'b1;
    if (pop) expand(mfifo.pop_front());
    if (acc) mfifo.push_back({bus.last, bus.odd, bus.data});
  endtask

  function automatic logic [3:0] exp_serial();
    return (wave.size() > 0) ? wave[0] : 4'b0000;
  endfunction

  task automatic check();
    logic [3:0] obs_s, exp_s;
    logic [1:0] obs_f, exp_f;
    obs_s = {bus.tx_load, bus.tx_data, bus.tx_stop, bus.msg_done};
    exp_s = exp_serial();
    obs_f = {bus.busy, bus.ovf};
    exp_f = {(mfifo.size() >= FIFO_DEPTH - 2), m_ovf};
    n_checks++;
    assert (obs_s === exp_s) else begin
      n_fail++;
      $error("FAIL serial cyc=%0d load/data/stop/done observed=%b expected=%b", cyc, obs_s, exp_s);
    end
    n_checks++;
    assert (obs_f === exp_f) else begin
      n_fail++;
      $error("FAIL flags cyc=%0d busy/ovf observed=%b expected=%b", cyc, obs_f, exp_f);
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
    cyc++;
    check();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wr(input logic [15:0] d, input logic l, input logic o);
    bus.data = d;
    bus.last = l;
    bus.odd  = o;
    bus.ena  = 1'b1;
    tick();
    bus.ena  = 1'b0;
  endtask

  task automatic drain(input string tag, input int budget);
    int n;
    n = 0;
    while ((wave.size() > 0 || mfifo.size() > 0) && n < budget) begin
      tick();
      n++;
    end
    n_checks++;
    assert (n < budget) else begin
      n_fail++;
      $error("FAIL %s drain timeout observed=%0d cycles expected<%0d", tag, n, budget);
    end
    ticks(3);
  endtask

  initial begin
    logic [5:0] obs_all;
    logic       prev_load;
    int         guard;

    bus.data = '0;
    bus.ena  = 1'b0;
    bus.last = 1'b0;
    bus.odd  = 1'b0;

    // Reset state
    ticks(3);
    rst_n = 1'b1;
    ticks(2);

    // Single word, both bytes, one stop
    wr(16'hA55A, 1'b1, 1'b0);
    ticks(30);

    // Odd tail: low byte of the last word is never sent
    wr(16'h1234, 1'b0, 1'b0);
    wr(16'hC3FF, 1'b1, 1'b1);
    ticks(45);

    // Underrun mid-message
    wr(16'h0102, 1'b0, 1'b0);
    ticks(30);
    wr(16'h0304, 1'b1, 1'b0);
    ticks(40);

    // Back-to-back single-word messages
    wr(16'h5AC3, 1'b1, 1'b0);
    wr(16'h0FF0, 1'b1, 1'b0);
    ticks(60);

    // Back-pressure: 20 consecutive writes ignoring busy
    for (int i = 0; i < 20; i++)
      wr(16'(16'h1000 + i * 16'h0111), (i == 19), 1'b0);
    ticks(420);

    // Random words; busy usually honoured, sometimes ignored
    for (int i = 0; i < 50; i++) begin
      guard = 0;
      if ($urandom_range(0, 7) != 0) begin
        while (bus.busy && guard < 200) begin
          tick();
          guard++;
        end
      end
      wr(16'($urandom), ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)));
      ticks($urandom_range(0, 3));
    end
    guard = 0;
    while (bus.busy && guard < 200) begin
      tick();
      guard++;
    end
    wr(16'($urandom), 1'b1, 1'($urandom_range(0, 1)));
    drain("random", 4000);

    // Reset in the 4th bit of a byte with the FIFO nearly full
    for (int i = 0; i < 16; i++) wr(16'(16'hB000 + i), 1'b0, 1'b0);
    prev_load = exp_serial()[3];
    guard = 0;
    while (!(exp_serial()[3] && !prev_load) && guard < 60) begin
      prev_load = exp_serial()[3];
      tick();
      guard++;
    end
    n_checks++;
    assert (guard < 60) else begin
      n_fail++;
      $error("FAIL byte_start wait observed=%0d cycles expected<60", guard);
    end
    ticks(3);
    #2;
    rst_n = 1'b0;
    #1;
    obs_all = {bus.tx_data, bus.tx_load, bus.tx_stop, bus.msg_done, bus.busy, bus.ovf};
    n_checks++;
    assert (obs_all === 6'b0) else begin
      n_fail++;
      $error("FAIL async_reset data/load/stop/done/busy/ovf observed=%b expected=%b", obs_all, 6'b0);
    end
    ticks(3);
    rst_n = 1'b1;
    ticks(50);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_serializer.md
Name: spi_serializer

Overview:
- Per-channel transmit serializer: the outbound end of the board's serial link (TX_DATA/TX_LOAD/TX_STOP), with TX_CLK driven externally from the same system clock.
- Accepts 16-bit words written by the Cypress slave-FIFO reader (DATA/ENA) and buffers them in a small FIFO.
- Emits them as framed bytes, MSB-first: TX_LOAD qualifies each byte and a TX_STOP pulse closes each message.
- BUSY gives back-pressure to the Cypress reader.

Parameters:
- FIFO_DEPTH, 16: word FIFO depth; power of 2, >=4.
- GAP_CYCLES, 2: idle cycles (TX_LOAD low) between bytes and before TX_STOP; >=1.
- STOP_LEN, 1: TX_STOP high duration in cycles; >=1.

Ports:
- CLK  in  1  system clock; TX_CLK equals this clock.
- RST  in  1  asynchronous, active-low reset.
- DATA  in  16  word from Cypress, already byte-order corrected.
- ENA  in  1  write strobe; DATA/LAST/ODD valid when high.
- LAST  in  1  word is the final word of a message.
- ODD  in  1  with LAST: only DATA[15:8] is valid.
- BUSY  out  1  almost-full back-pressure.
- OVF  out  1  sticky: a write was dropped.
- TX_DATA  out  1  serial data.
- TX_LOAD  out  1  high during the 8 bit-cycles of each byte.
- TX_STOP  out  1  end-of-message marker.
- MSG_DONE  out  1  one-cycle pulse, message fully sent.

Behaviour:
- All outputs are registered and change only after rising CLK.
- RST low: FIFO emptied, FSM to IDLE, all outputs 0 (including OVF), asynchronously.
- FIFO entries are 18 bits {LAST, ODD, DATA}. A write is accepted when ENA=1 and (count<FIFO_DEPTH or a pop occurs in the same cycle); otherwise it is dropped and OVF is set, held until reset.
- BUSY = (count >= FIFO_DEPTH-2), computed from the registered count. This gives 2 words of slack for reader latency.
- FSM states:
  - IDLE: if FIFO is non-empty, pop the word into the shift register and go to SHIFT.
  - SHIFT: 8 cycles. TX_LOAD=1, TX_DATA = current bit, MSB first. The high byte DATA[15:8] is sent first, then DATA[7:0].
  - GAP: GAP_CYCLES cycles with TX_LOAD=0 and TX_DATA=0. Exit by case:
    - after a high byte not flagged ODD-last: return to SHIFT for the low byte;
    - after the low byte of a non-last word: pop the next word and go to SHIFT if the FIFO is non-empty, else go to WAIT;
    - after the final byte of the message: go to STOP.
  - WAIT (underrun mid-message): TX_LOAD=0, no TX_STOP. Pop and go to SHIFT as soon as the FIFO is non-empty.
  - STOP: TX_STOP=1 for STOP_LEN cycles. MSG_DONE=1 in the last STOP cycle. Then go to IDLE.
- The pop happens on the transition edge, so the first bit appears in the cycle immediately after the pop.
- Latency: ENA high in cycle k, FSM idle with FIFO empty → TX_LOAD high from cycle k+2.
- Final byte of a message:
  - the low byte of a LAST word;
  - or the high byte when LAST=1 and ODD=1, in which case the low byte is skipped.
  - ODD with LAST=0 is ignored; both bytes are sent.
- From IDLE the next message may start the cycle after the last STOP cycle.
- Reset mid-byte: outputs drop to 0 immediately, with no STOP. After release, transmission restarts only with newly written words.

Test Plan:
- Single word, GAP_CYCLES=2, STOP_LEN=1: DATA=0xA55A, LAST=1, ODD=0, ENA in cycle 0 → TX_LOAD=1 in cycles 2-9 with TX_DATA 1,0,1,0,0,1,0,1; low in 10-11; TX_LOAD=1 in 12-19 with TX_DATA 0,1,0,1,1,0,1,0; low in 20-21; TX_STOP=1 and MSG_DONE=1 in cycle 22; all 0 in cycle 23.
- Odd tail: words 0x1234 (LAST=0) then 0xC3FF (LAST=1, ODD=1), back-to-back → bytes 0x12, 0x34, 0xC3 each separated by 2 gap cycles; 0xFF never sent; exactly one TX_STOP pulse.
- Underrun: write 0x0102 (LAST=0), then wait 30 cycles, then write 0x0304 (LAST=1) → TX_STOP stays 0 during the wait; bytes 0x03 and 0x04 follow; one STOP at the end.
- Back-pressure, FIFO_DEPTH=16: write 20 words (LAST only on the 20th) on consecutive cycles, ignoring BUSY → BUSY rises once count reaches 14; OVF=1 once a write hits a full FIFO with no pop that cycle; exactly the dropped words are absent from the serial stream.
- Reset mid-operation: assert RST in the 4th bit of a byte → TX_DATA, TX_LOAD, TX_STOP, BUSY and OVF go to 0 without a clock edge; after release with no new writes, outputs stay idle for 50 cycles.
- Back-to-back messages: two single-word LAST messages written together → second message's TX_LOAD rises 2 cycles after the first MSG_DONE (IDLE cycle, then pop); two distinct STOP pulses.
